// File: rtl/weight_loader_if.sv
// AXI-Stream word channel feeding the weight loader.
// The master drives valid/data/last and the slave returns ready.
interface weight_loader_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tlast;

    modport master (
        output s_axis_tvalid,
        output s_axis_tdata,
        output s_axis_tlast,
        input  s_axis_tready
    );

    modport slave (
        input  s_axis_tvalid,
        input  s_axis_tdata,
        input  s_axis_tlast,
        output s_axis_tready
    );
endinterface

// File: rtl/weight_loader.sv
// Streams one packet of weight words into the weight BRAM from address 0.
// Checks the packet length against tlast and reports done/error levels.
module weight_loader #(
    parameter int DATA_WIDTH   = 16,
    parameter int NO_OF_WEIGHT = 784,
    parameter int ADDRS_WIDTH  = $clog2(NO_OF_WEIGHT)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    weight_loader_if.slave         axis,
    output logic                   bram_we,
    output logic [ADDRS_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0]  bram_wdata,
    output logic                   load_busy,
    output logic                   load_done,
    output logic                   err_len,
    output logic [ADDRS_WIDTH:0]   word_count
);
    localparam int CW = ADDRS_WIDTH + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NO_OF_WEIGHT - 1);
    localparam logic [ADDRS_WIDTH-1:0] LAST_ADDR =
        ADDRS_WIDTH'(NO_OF_WEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDRS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          word_count_q, word_count_d;
    logic                   we_q, we_d;
    logic [ADDRS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;

    logic accept;
    logic final_beat;

    assign accept     = axis.s_axis_tvalid & axis.s_axis_tready;
    assign final_beat = (word_count_q == LAST_BEAT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            word_count_q <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            word_count_q <= word_count_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: begin
                if (accept) begin
                    if (axis.s_axis_tlast)
                        state_d = final_beat ? DONE : ERR;
                    else if (final_beat)
                        state_d = ERR;
                end
            end
            DONE: if (start) state_d = LOAD;
            ERR:  if (start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    // Write port is registered: the accepted beat lands one edge later.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        word_count_d = word_count_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        if (start && state_q != LOAD) begin
            wr_ptr_d     = '0;
            word_count_d = '0;
        end else if (accept) begin
            we_d         = 1'b1;
            addr_d       = wr_ptr_q;
            wdata_d      = axis.s_axis_tdata;
            word_count_d = word_count_q + CW'(1);
            if (wr_ptr_q != LAST_ADDR)
                wr_ptr_d = wr_ptr_q + ADDRS_WIDTH'(1);
        end
    end

    always_comb begin
        axis.s_axis_tready = (state_q == LOAD);
        load_busy          = (state_q == LOAD);
        load_done          = (state_q == DONE);
        err_len            = (state_q == ERR);
        bram_we            = we_q;
        bram_addr          = addr_q;
        bram_wdata         = wdata_q;
        word_count         = word_count_q;
    end
endmodule

// File: tb/tb_weight_loader.sv
// Directed-random bench for weight_loader against a packet-level model.
// The model tracks beats, BRAM contents and the done/error outcome.
module tb_weight_loader;
    localparam int DW = 16;
    localparam int N  = 784;
    localparam int AW = $clog2(N);

    localparam int S_IDLE = 0;
    localparam int S_LOAD = 1;
    localparam int S_DONE = 2;
    localparam int S_ERR  = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata;
    logic          load_busy;
    logic          load_done;
    logic          err_len;
    logic [AW:0]   word_count;

    weight_loader_if #(.DATA_WIDTH(DW)) axis_if ();

    weight_loader #(
        .DATA_WIDTH  (DW),
        .NO_OF_WEIGHT(N),
        .ADDRS_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .axis      (axis_if),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_wdata(bram_wdata),
        .load_busy (load_busy),
        .load_done (load_done),
        .err_len   (err_len),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int m_st;
    int m_cnt;
    int m_addr;
    int m_wdata;
    int exp_mem [N];
    int got_mem [N];
    int wr_hits [N];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st    = S_IDLE;
        m_cnt   = 0;
        m_addr  = 0;
        m_wdata = 0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < N; i++) begin
            got_mem[i] = -1;
            exp_mem[i] = -2;
            wr_hits[i] = 0;
        end
    endtask

    // One clock cycle: drive, check ready mid-cycle, check outputs after the edge.
    task automatic step(input bit v, input int d, input bit l,
                        input bit st, output bit acc);
        int pre;
        axis_if.s_axis_tvalid = v;
        axis_if.s_axis_tdata  = d[DW-1:0];
        axis_if.s_axis_tlast  = l;
        start                 = st;
        @(negedge clk);
        pre = m_st;
        chk("tready", {31'd0, axis_if.s_axis_tready}, {31'd0, pre == S_LOAD});
        acc = v && (pre == S_LOAD);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (acc) begin
            exp_mem[m_cnt] = d & 32'hFFFF;
            m_addr  = m_cnt;
            m_wdata = d & 32'hFFFF;
            m_cnt++;
            if (l)
                m_st = (m_cnt == N) ? S_DONE : S_ERR;
            else if (m_cnt == N)
                m_st = S_ERR;
        end else if (st && pre != S_LOAD) begin
            m_st  = S_LOAD;
            m_cnt = 0;
        end
        if (bram_we === 1'b1 && !$isunknown(bram_addr) && int'(bram_addr) < N) begin
            got_mem[bram_addr] = int'(bram_wdata);
            wr_hits[bram_addr]++;
        end
        chk("bram_we", {31'd0, bram_we}, {31'd0, acc});
        chk("bram_addr", 32'(bram_addr), m_addr);
        chk("bram_wdata", 32'(bram_wdata), m_wdata);
        chk("load_busy", {31'd0, load_busy}, {31'd0, m_st == S_LOAD});
        chk("load_done", {31'd0, load_done}, {31'd0, m_st == S_DONE});
        chk("err_len", {31'd0, err_len}, {31'd0, m_st == S_ERR});
        chk("word_count", 32'(word_count), m_cnt);
    endtask

    task automatic do_start();
        bit acc;
        clear_mem();
        step(1'b0, 0, 1'b0, 1'b1, acc);
    endtask

    // n accepted beats; last_at=0 means no tlast; start_at=0 means no stray start.
    task automatic send_pkt(input int n, input int last_at, input int gap_pct,
                            input bit incr, input int start_at);
        int i;
        int d;
        bit v;
        bit acc;
        i = 0;
        d = incr ? 32'h1000 : int'($urandom_range(16'hFFFF));
        while (i < n) begin
            v = ($urandom_range(99) >= gap_pct);
            step(v, d, (i + 1) == last_at, v && start_at != 0 && i == start_at - 1, acc);
            if (acc) begin
                i++;
                d = incr ? 32'h1000 + i : int'($urandom_range(16'hFFFF));
            end
        end
    endtask

    task automatic check_mem(input int n);
        for (int i = 0; i < N; i++) begin
            chk("mem_hits", wr_hits[i], (i < n) ? 1 : 0);
            if (i < n)
                chk("mem_data", got_mem[i], exp_mem[i]);
        end
    endtask

    task automatic reset_checks();
        chk("rst_we", {31'd0, bram_we}, 0);
        chk("rst_addr", 32'(bram_addr), 0);
        chk("rst_wdata", 32'(bram_wdata), 0);
        chk("rst_tready", {31'd0, axis_if.s_axis_tready}, 0);
        chk("rst_busy", {31'd0, load_busy}, 0);
        chk("rst_done", {31'd0, load_done}, 0);
        chk("rst_err", {31'd0, err_len}, 0);
        chk("rst_count", 32'(word_count), 0);
    endtask

    initial begin
        bit acc;
        axis_if.s_axis_tvalid = 1'b0;
        axis_if.s_axis_tdata  = '0;
        axis_if.s_axis_tlast  = 1'b0;
        model_reset();
        clear_mem();
        #1;
        reset_checks();
        #12;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle with valid high: nothing accepted without start
        for (int k = 0; k < 3; k++)
            step(1'b1, 32'h55AA, 1'b0, 1'b0, acc);

        // Nominal back-to-back packet
        do_start();
        send_pkt(N, N, 0, 1'b1, 0);
        check_mem(N);
        step(1'b0, 0, 1'b0, 1'b0, acc);

        // Random valid gaps, random data
        do_start();
        send_pkt(N, N, 50, 1'b0, 0);
        check_mem(N);

        // Short packet
        do_start();
        send_pkt(10, 10, 30, 1'b0, 0);
        check_mem(10);
        step(1'b1, 32'h1234, 1'b1, 1'b0, acc);

        // Long packet; beat 785 held valid and never taken
        do_start();
        send_pkt(N, 0, 20, 1'b0, 0);
        check_mem(N);
        for (int k = 0; k < 3; k++)
            step(1'b1, 32'hBEEF, 1'b1, 1'b0, acc);

        // Reset in the middle of a packet, away from the clock edge
        do_start();
        send_pkt(300, 0, 0, 1'b0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        reset_checks();
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 32'h7777, 1'b0, 1'b0, acc);
        do_start();
        send_pkt(N, N, 25, 1'b0, 0);
        check_mem(N);

        // Stray start at beat 50 is ignored
        do_start();
        send_pkt(N, N, 0, 1'b0, 50);
        check_mem(N);
        step(1'b0, 0, 1'b0, 1'b0, acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
AXI-Stream slave that receives a block of NO_OF_WEIGHT weight words and writes them sequentially into the weight BRAM through its write port (we/addr/din). It is the write-side counterpart of the BRAM-to-stream weight reader. It fills the BRAM from address 0 before inference starts. It also checks the packet length against s_axis_tlast and reports done/error status to the controller.

Parameters:
DATA_WIDTH, 16, width of one weight word and of the BRAM data port
NO_OF_WEIGHT, 784, number of words per load packet; the BRAM depth used
ADDRS_WIDTH, $clog2(NO_OF_WEIGHT), width of the BRAM address port

Ports:
clk  input  1  single clock; all logic on posedge
reset_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; arms a new load from address 0
s_axis_tvalid  input  1  upstream word valid
s_axis_tready  output  1  loader ready to accept a word
s_axis_tdata  input  DATA_WIDTH  weight word
s_axis_tlast  input  1  marks the final word of the packet
bram_we  output  1  BRAM write enable (also drives BRAM ena)
bram_addr  output  ADDRS_WIDTH  BRAM write address
bram_wdata  output  DATA_WIDTH  BRAM write data
load_busy  output  1  high while in LOAD
load_done  output  1  high in DONE state
err_len  output  1  high in ERR state (tlast mismatch)
word_count  output  ADDRS_WIDTH+1  number of words accepted in the current or most recent load

Behaviour:
- Reset (async, reset_n=0): state=IDLE, s_axis_tready=0, bram_we=0, bram_addr=0, bram_wdata=0, load_busy=0, load_done=0, err_len=0, word_count=0. Reset mid-load abandons the packet; no further writes occur. A fresh start is required after reset.
- FSM states: IDLE, LOAD, DONE, ERR.
  - IDLE -> LOAD on start.
  - LOAD -> DONE when the accepted beat is number NO_OF_WEIGHT and has tlast=1.
  - LOAD -> ERR when the accepted beat has tlast=1 and beat number < NO_OF_WEIGHT (short packet).
  - LOAD -> ERR when the accepted beat is number NO_OF_WEIGHT and has tlast=0 (long or unterminated packet).
  - DONE or ERR -> LOAD on start; word_count and the write pointer clear to 0 on entry. DONE and ERR hold until start.
- start in LOAD is ignored.
- s_axis_tready = (state==LOAD), decoded combinationally from the state register only; it does not depend on tvalid.
- Handshake: a beat is accepted when s_axis_tvalid & s_axis_tready. Upstream holds tdata/tlast stable while valid and not ready (AXI rule); the loader takes no action on unaccepted cycles.
- Write latency is 1 cycle. On the edge after an accepted beat: bram_we=1, bram_addr=wr_ptr, bram_wdata=tdata. Then wr_ptr and word_count each increment by 1.
- bram_we is 0 on any cycle not following an accepted beat. bram_addr and bram_wdata hold their last values when bram_we=0.
- The beat that triggers ERR or DONE is still written. An ERR caused by a long packet writes exactly NO_OF_WEIGHT words; wr_ptr never wraps and never exceeds NO_OF_WEIGHT-1.
- load_done and err_len assert on the same edge as the final write. They are level signals, mutually exclusive, and both clear on start.
- Back-to-back beats sustain 1 word per clock with no bubbles.

Test Plan:
- Nominal load: start, then 784 back-to-back beats with tdata=0x1000+i and tlast on beat 784 -> 784 writes, addr 0..783, wdata 0x1000..0x130F; load_done=1 one cycle after the last handshake; word_count=784; tready=0 afterwards.
- Backpressure and gaps: tvalid toggles randomly (about 50%) for a full packet -> writes only on cycles following a handshake; addresses contiguous with no duplicates; final state DONE.
- Short packet: tlast on beat 10 -> 10 writes (addr 0..9), err_len=1, load_done=0, word_count=10, tready=0; a following start returns to LOAD with word_count=0.
- Long packet: no tlast through beat 784 -> 784 writes, err_len=1 after beat 784, tready=0; beat 785 is never accepted.
- Reset mid-load: assert reset_n=0 asynchronously (between clock edges) after beat 300 -> all outputs 0 immediately, state IDLE; a subsequent start and full packet write from addr 0 and reach DONE.
- start pulse while in LOAD at beat 50 -> ignored; load continues to addr 783 and reaches DONE with word_count=784.
